// File: rtl/adder_flag_accum.sv
// Streaming 16-bit batch accumulator with per-add flags and batch-wide
// sticky carry/overflow, valid/ready on both sides.
module adder_flag_accum #(
   parameter int N_OPS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   input  logic        clear,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_sum,
   output logic        out_sign,
   output logic        out_zero,
   output logic        out_carry,
   output logic        out_parity,
   output logic        out_overflow,
   output logic        sticky_carry,
   output logic        sticky_ovf,
   output logic [7:0]  op_count
);

   localparam logic [0:0] ACCUM = 1'b0;
   localparam logic [0:0] DONE  = 1'b1;
   localparam logic [7:0] LAST  = 8'(N_OPS - 1);

   logic [0:0]  state;
   logic        live;
   logic [16:0] sum;
   logic [15:0] res;
   logic        ovf;
   logic        accept;
   logic        wipe;

   // live keeps in_ready low until the first edge after reset release
   assign in_ready  = live & (state == ACCUM);
   assign out_valid = (state == DONE);

   assign sum    = {1'b0, out_sum} + {1'b0, in_data};
   assign res    = sum[15:0];
   assign ovf    = (out_sum[15] & in_data[15] & ~res[15]) |
                   (~out_sum[15] & ~in_data[15] & res[15]);
   assign accept = in_valid & in_ready;
   assign wipe   = clear | (out_valid & out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ACCUM;
         live         <= 1'b0;
         out_sum      <= '0;
         out_sign     <= 1'b0;
         out_zero     <= 1'b0;
         out_carry    <= 1'b0;
         out_parity   <= 1'b0;
         out_overflow <= 1'b0;
         sticky_carry <= 1'b0;
         sticky_ovf   <= 1'b0;
         op_count     <= '0;
      end else begin
         live <= 1'b1;
         if (wipe) begin
            state        <= ACCUM;
            out_sum      <= '0;
            out_sign     <= 1'b0;
            out_zero     <= 1'b0;
            out_carry    <= 1'b0;
            out_parity   <= 1'b0;
            out_overflow <= 1'b0;
            sticky_carry <= 1'b0;
            sticky_ovf   <= 1'b0;
            op_count     <= '0;
         end else if (accept) begin
            out_sum      <= res;
            out_sign     <= res[15];
            out_zero     <= (res == 16'h0000);
            out_carry    <= sum[16];
            out_parity   <= ~^res;
            out_overflow <= ovf;
            sticky_carry <= sticky_carry | sum[16];
            sticky_ovf   <= sticky_ovf | ovf;
            op_count     <= op_count + 8'd1;
            if (op_count == LAST) state <= DONE;
         end
      end
   end

endmodule

// File: doc/adder_flag_accum.md
# adder_flag_accum

Streaming 16-bit accumulator that sits directly upstream of the flagged 16-bit adder's consumers and reuses the adder's flag semantics. It accepts a batch of `N_OPS` operands over a valid/ready input and sums them into a 16-bit register. It then presents the wrapped sum with the flags of the final addition, plus sticky carry/overflow for the whole batch, on a valid/ready output. It is the sequential front end of the ALU datapath: upstream logic streams operands in, and the result/flag word goes downstream to the flag register file.

## Interface
- `N_OPS`, default 4: operands per batch, legal range 1..255.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: block accepts an operand this cycle.
- `in_data` in 16: operand, unsigned or two's complement.
- `clear` in 1: synchronous batch abort.
- `out_valid` out 1: result is valid.
- `out_ready` in 1: downstream accepts the result.
- `out_sum` out 16: accumulated sum, modulo 2^16.
- `out_sign`, `out_zero`, `out_carry`, `out_parity`, `out_overflow` out 1 each: flags of the last addition.
- `sticky_carry`, `sticky_ovf` out 1 each: OR of carry and overflow over all additions in the batch.
- `op_count` out 8: operands accepted in the current batch.

## Operation
- FSM has two states.
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- Accept rule: an operand is accepted when `in_valid & in_ready`.
  - `acc <= acc + in_data`.
  - The five flags are registered from that addition.
  - Stickies OR in the carry and overflow of that addition.
  - `op_count` increments.
- First addition of a batch is 0 + operand.
- Batch end: when the accepted operand is number `N_OPS`, the FSM moves ACCUM→DONE and `op_count` reads `N_OPS`.
- Output handshake: in DONE, `out_valid & out_ready` causes DONE→ACCUM, and `acc`, flags, stickies and `op_count` all clear to 0.
- In DONE the outputs hold steady for any number of cycles while `out_ready`=0. `in_valid` is ignored.
- Flag definitions, where s = `acc`, o = `in_data`, r = the 16-bit result:
  - sign = r[15]
  - zero = (r == 0)
  - carry = bit 16 of the 17-bit sum s + o
  - parity = XNOR-reduce of r (1 = even number of ones)
  - overflow = (s[15] & o[15] & ~r[15]) | (~s[15] & ~o[15] & r[15])
- `clear`: in either state, return to ACCUM and zero `acc`, flags, stickies and `op_count`.
  - `out_valid` drops the next cycle.
  - An operand presented in the same cycle as `clear` is discarded.
  - `clear` has priority over accept and over the output handshake.
- Arithmetic is a 17-bit internal sum; only bits [15:0] are stored.

## Timing
- Reset values: state ACCUM; `acc`, `out_sum`, all flags, stickies and `op_count` = 0; `out_valid` = 0.
  - `in_ready` is forced 0 while `rst_n` is low.
  - `in_ready` = 1 from the first edge after `rst_n` deasserts.
  - `out_zero` is 0 after reset; no addition has happened yet.
- Reset asserted mid-batch or in DONE: all state returns to reset values immediately, with no clock needed. The partial batch is lost.
- Accepted operand is visible in `out_sum` and the flags after 1 cycle.
- `out_valid` rises on the edge that accepts the final operand.
- DONE→ACCUM happens on the output-handshake edge. `in_ready` is 1 the following cycle; there is no same-cycle bypass.
- Minimum batch period is `N_OPS` + 1 cycles.
- `out_*`, `op_count` and stickies are direct register outputs. `in_ready` and `out_valid` decode state only, with no combinational path from inputs.

## Test plan
- `N_OPS`=2, stream 0x8FFF, 0x8000, `out_ready`=1 → `out_sum`=0x0FFF, sign=0, zero=0, carry=1, parity=1, overflow=1, `sticky_carry`=1, `sticky_ovf`=1, `op_count`=2.
- `N_OPS`=2, stream 0xFFFE, 0x0002 → `out_sum`=0x0000, zero=1, carry=1, parity=1, overflow=0, sign=0; next batch 0xAAAA, 0x5555 → `out_sum`=0xFFFF, sign=1, carry=0, overflow=0, parity=1, both stickies=0.
- `N_OPS`=3, stream 0x8000, 0x8000, 0x0001 → `out_sum`=0x0001, carry=0, overflow=0, parity=0, `sticky_carry`=1, `sticky_ovf`=1.
- Backpressure: batch completes with `out_ready`=0 for 4 cycles while `in_valid`=1 and `in_data`=0x1234 → `out_valid` and `out_sum` stable, `in_ready`=0, no extra accumulation; `out_ready`=1 → `op_count`=0 and `in_ready`=1 one cycle later.
- `in_valid` gaps: `N_OPS`=4, operands 1, 2, 3, 4 with idle cycles between them → `out_sum`=0x000A; `op_count` steps 1, 2, 3, 4 only on accept edges.
- `clear` after 2 of 4 operands, `clear` coincident with an operand, and `rst_n` pulsed low mid-batch between clock edges → all outputs return to 0 immediately on reset or next edge on clear; the following full batch sums correctly from 0.
